// File: rtl/uart_rx_fifo_if.sv
// Bundle of receiver, consumer and status signals for uart_rx_fifo.
// ADDR_W must match the ADDR_W of the attached uart_rx_fifo instance.
interface uart_rx_fifo_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic [3:0]        char_size;
  logic              rd_en;
  logic              ovr_clr;
  logic [7:0]        rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun;

  // Master: receiver plus consumer side that drives the FIFO.
  modport master (
    output rx_rdy, rx_data, char_size, rd_en, ovr_clr,
    input  rd_data, empty, full, count, overrun
  );

  // Slave: the FIFO itself.
  modport slave (
    input  rx_rdy, rx_data, char_size, rd_en, ovr_clr,
    output rd_data, empty, full, count, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: synchronizes the receiver's ready flag,
// pushes one masked character per rising edge of that flag, and lets a
// consumer pop bytes through a registered read port. Overflow is sticky.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);

  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);

  logic                s1_q, s2_q, s3_q;
  logic                rx_edge;
  logic [7:0]          char_mask;
  logic [7:0]          push_data;

  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovr_q, ovr_d;
  logic [7:0]          rd_data_q, rd_data_d;

  logic                empty, full;
  logic                pop_ok, push_ok, drop;

  // Synchronizer and history flop; they reset to 1 so a receiver that idles
  // ready (or is held high through reset) never looks like a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= bus.rx_rdy;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rx_edge = s2_q & ~s3_q;

  // Bits above the configured width are zeroed; out-of-range widths mean 8.
  always_comb begin
    char_mask = 8'hFF;
    case (bus.char_size)
      4'd5:    char_mask = 8'h1F;
      4'd6:    char_mask = 8'h3F;
      4'd7:    char_mask = 8'h7F;
      default: char_mask = 8'hFF;
    endcase
  end

  assign push_data = bus.rx_data & char_mask;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

  // A pop while full frees the slot the simultaneous push lands in.
  assign pop_ok  = bus.rd_en & ~empty;
  assign push_ok = rx_edge & (~full | pop_ok);
  assign drop    = rx_edge & full & ~pop_ok;

  // Next-state for pointers, occupancy, read register and sticky overrun.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    ovr_d     = ovr_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop_ok) begin
      rd_ptr_d  = rd_ptr_q + PtrOne;
      rd_data_d = mem_q[rd_ptr_q];
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set beats clear when both happen together.
    if (drop) begin
      ovr_d = 1'b1;
    end else if (bus.ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  // Control state; reset overrides every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= 8'h00;
      ovr_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      ovr_q     <= ovr_d;
    end
  end

  // Storage array; contents are left as-is on reset since count gates reads.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.count   = count_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;

  typedef logic [ADDR_W+11:0] state_t;  // {count, empty, full, overrun, rd_data}

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of stored bytes, the sticky flag and the
  // last byte handed to the consumer.
  logic [7:0] model_q [$];
  logic       model_ovr;
  logic [7:0] model_rd;

  function automatic state_t model_state();
    logic [ADDR_W:0] c;
    c = (ADDR_W + 1)'(model_q.size());
    return {c, model_q.size() == 0, model_q.size() == DEPTH, model_ovr, model_rd};
  endfunction

  function automatic state_t dut_state();
    return {bus.count, bus.empty, bus.full, bus.overrun, bus.rd_data};
  endfunction

  function automatic logic [7:0] model_mask(input logic [7:0] d, input logic [3:0] cs);
    int w;
    w = (cs >= 5 && cs <= 8) ? int'(cs) : 8;
    return d & 8'((1 << w) - 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One character from the receiver: ready low long enough to be seen, then
  // high; returns just after the edge that performs the push. Optionally pops
  // on that same edge.
  task automatic send_byte(input logic [7:0] d, input logic [3:0] cs, input bit with_pop);
    bus.rx_rdy = 1'b0;
    repeat (3) step();
    bus.rx_data   = d;
    bus.char_size = cs;
    bus.rx_rdy    = 1'b1;
    step();
    step();
    if (with_pop) bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    if (with_pop && model_q.size() > 0) model_rd = model_q.pop_front();
    if (model_q.size() < DEPTH) model_q.push_back(model_mask(d, cs));
    else model_ovr = 1'b1;
  endtask

  task automatic pop_byte();
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    if (model_q.size() > 0) model_rd = model_q.pop_front();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_q.delete();
    model_ovr = 1'b0;
    model_rd  = 8'h00;
  endtask

  task automatic test_reset();
    bus.rx_rdy = 1'b1;
    bus.rx_data = 8'h00;
    bus.char_size = 4'd8;
    bus.rd_en = 1'b0;
    bus.ovr_clr = 1'b0;
    do_reset();
    step();
    checks++;
    if (dut_state() !== {4'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", dut_state(), {4'd0, 4'b1000, 8'h00});
    end
  endtask

  task automatic test_single_byte();
    bus.rx_rdy = 1'b0;
    repeat (3) step();
    bus.rx_data = 8'hA5;
    bus.char_size = 4'd8;
    bus.rx_rdy = 1'b1;
    step();
    step();
    checks++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL latency_early: got count %0d empty %b want 0 1", bus.count, bus.empty);
    end
    step();
    model_q.push_back(8'hA5);
    checks++;
    if (bus.count !== 4'd1 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL latency_push: got count %0d empty %b want 1 0", bus.count, bus.empty);
    end
    pop_byte();
    checks++;
    if (bus.rd_data !== 8'hA5 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL single_pop: got %h empty %b want a5 1", bus.rd_data, bus.empty);
    end
    // Pop while empty must change nothing.
    pop_byte();
    checks++;
    if (dut_state() !== model_state()) begin
      errors++;
      $display("FAIL pop_empty: got %h want %h", dut_state(), model_state());
    end
  endtask

  task automatic test_held_high();
    repeat (8) step();
    checks++;
    if (bus.count !== 4'd0) begin
      errors++;
      $display("FAIL held_high: got count %0d want 0", bus.count);
    end
  endtask

  task automatic test_masking();
    send_byte(8'hFF, 4'd5, 1'b0);
    pop_byte();
    checks++;
    if (bus.rd_data !== 8'h1F) begin
      errors++;
      $display("FAIL mask_5: got %h want 1f", bus.rd_data);
    end
    send_byte(8'hFF, 4'd3, 1'b0);
    pop_byte();
    checks++;
    if (bus.rd_data !== 8'hFF) begin
      errors++;
      $display("FAIL mask_3: got %h want ff", bus.rd_data);
    end
    for (int i = 0; i < 12; i++) begin
      send_byte(8'($urandom), 4'($urandom_range(0, 15)), 1'b0);
      pop_byte();
      checks++;
      if (dut_state() !== model_state()) begin
        errors++;
        $display("FAIL mask_rand%0d: got %h want %h", i, dut_state(), model_state());
      end
    end
  endtask

  task automatic test_fill_overrun();
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), 4'd8, 1'b0);
      if (i == 8) begin
        checks++;
        if (bus.full !== 1'b1 || bus.overrun !== 1'b0) begin
          errors++;
          $display("FAIL fill_8: got full %b ovr %b want 1 0", bus.full, bus.overrun);
        end
      end
    end
    checks++;
    if (bus.overrun !== 1'b1 || bus.count !== 4'd8) begin
      errors++;
      $display("FAIL overrun_9: got ovr %b count %0d want 1 8", bus.overrun, bus.count);
    end
    for (int i = 1; i <= 8; i++) begin
      pop_byte();
      checks++;
      if (bus.rd_data !== 8'(i)) begin
        errors++;
        $display("FAIL fill_pop%0d: got %h want %h", i, bus.rd_data, 8'(i));
      end
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL drained: got empty %b ovr %b want 1 1", bus.empty, bus.overrun);
    end
    bus.ovr_clr = 1'b1;
    step();
    bus.ovr_clr = 1'b0;
    model_ovr = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clr: got %b want 0", bus.overrun);
    end
    // Clear held during a dropping push: the set must win.
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 4'd8, 1'b0);
    bus.ovr_clr = 1'b1;
    send_byte(8'hEE, 4'd8, 1'b0);
    bus.ovr_clr = 1'b0;
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: got %b want 1", bus.overrun);
    end
    for (int i = 0; i < DEPTH; i++) pop_byte();
    checks++;
    if (dut_state() !== model_state()) begin
      errors++;
      $display("FAIL set_wins_drain: got %h want %h", dut_state(), model_state());
    end
    bus.ovr_clr = 1'b1;
    step();
    bus.ovr_clr = 1'b0;
    model_ovr = 1'b0;
  endtask

  task automatic test_full_boundary();
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 4'd8, 1'b0);
    send_byte(8'h55, 4'd8, 1'b1);
    checks++;
    if (bus.count !== 4'd8 || bus.overrun !== 1'b0 || bus.rd_data !== model_rd) begin
      errors++;
      $display("FAIL full_pushpop: got count %0d ovr %b rd %h want 8 0 %h",
               bus.count, bus.overrun, bus.rd_data, model_rd);
    end
    for (int i = 0; i < DEPTH; i++) begin
      pop_byte();
      checks++;
      if (dut_state() !== model_state()) begin
        errors++;
        $display("FAIL full_drain%0d: got %h want %h", i, dut_state(), model_state());
      end
    end
    checks++;
    if (bus.rd_data !== 8'h55) begin
      errors++;
      $display("FAIL full_last: got %h want 55", bus.rd_data);
    end
  endtask

  task automatic test_empty_pushpop();
    logic [7:0] prev;
    prev = model_rd;
    send_byte(8'h3C, 4'd8, 1'b1);
    checks++;
    if (bus.count !== 4'd1 || bus.rd_data !== prev) begin
      errors++;
      $display("FAIL empty_pushpop: got count %0d rd %h want 1 %h", bus.count, bus.rd_data, prev);
    end
    // Partially filled: push and pop together keep the count.
    send_byte(8'h4D, 4'd8, 1'b0);
    send_byte(8'h5E, 4'd8, 1'b1);
    checks++;
    if (dut_state() !== model_state() || bus.count !== 4'd2) begin
      errors++;
      $display("FAIL mid_pushpop: got %h want %h", dut_state(), model_state());
    end
    pop_byte();
    pop_byte();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(8'h30 + i), 4'd8, 1'b0);
      pop_byte();
      checks++;
      if (bus.rd_data !== 8'(8'h30 + i)) begin
        errors++;
        $display("FAIL wrap%0d: got %h want %h", i, bus.rd_data, 8'(8'h30 + i));
      end
    end
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_empty: got %b want 1", bus.empty);
    end
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 70; i++) begin
      case ($urandom_range(0, 5))
        0, 1: send_byte(8'($urandom), 4'($urandom_range(0, 15)), 1'b0);
        2, 3: pop_byte();
        4:    send_byte(8'($urandom), 4'($urandom_range(0, 15)), 1'b1);
        default: begin
          bus.ovr_clr = 1'b1;
          step();
          bus.ovr_clr = 1'b0;
          model_ovr = 1'b0;
        end
      endcase
      checks++;
      if (dut_state() !== model_state()) begin
        errors++;
        $display("FAIL mix%0d: got %h want %h", i, dut_state(), model_state());
      end
    end
  endtask

  task automatic test_reset_mid();
    if (model_q.size() > 0) do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 4'd8, 1'b0);
    do_reset();
    checks++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: got count %0d empty %b rd %h want 0 1 00",
               bus.count, bus.empty, bus.rd_data);
    end
    repeat (6) step();
    checks++;
    if (bus.count !== 4'd0) begin
      errors++;
      $display("FAIL reset_held_rdy: got count %0d want 0", bus.count);
    end
    // Rise whose detected edge lands on the reset cycle is discarded.
    bus.rx_rdy = 1'b0;
    repeat (3) step();
    bus.rx_rdy = 1'b1;
    step();
    step();
    do_reset();
    repeat (6) step();
    checks++;
    if (dut_state() !== {4'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_edge: got %h want %h", dut_state(), {4'd0, 4'b1000, 8'h00});
    end
    // Normal operation resumes afterwards.
    send_byte(8'h9A, 4'd8, 1'b0);
    pop_byte();
    checks++;
    if (bus.rd_data !== 8'h9A || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: got %h empty %b want 9a 1", bus.rd_data, bus.empty);
    end
  endtask

  initial begin
    model_ovr = 1'b0;
    model_rd  = 8'h00;
    rst = 1'b1;
    test_reset();
    test_single_byte();
    test_held_high();
    test_masking();
    test_fill_overrun();
    test_full_boundary();
    test_empty_pushpop();
    test_wrap();
    test_random_mix();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, default 8, FIFO entries; SHALL be a power of 2, at least 2.
REQ-002 Parameter: ADDR_W, default 3, SHALL equal log2(DEPTH).
REQ-003 clk  input  1  system clock; the block SHALL have exactly one clock domain (clk), and all flops SHALL be clocked on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx_rdy  input  1  receiver ready flag, asynchronous to clk; its rising edge marks a completed character.
REQ-006 rx_data  input  8  received character from the receiver, stable while rx_rdy is high.
REQ-007 char_size  input  4  configured character width in bits, legal values 5-8.
REQ-008 rd_en  input  1  pop request from the consumer.
REQ-009 rd_data  output  8  registered head byte, valid the cycle after an accepted pop.
REQ-010 empty  output  1  high when count is 0.
REQ-011 full  output  1  high when count equals DEPTH.
REQ-012 count  output  ADDR_W+1  number of stored bytes.
REQ-013 overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-014 ovr_clr  input  1  clears overrun.

Function
REQ-015 rx_rdy SHALL pass through a two-flop synchronizer (s1, s2) followed by a history flop (s3); a detected edge SHALL be s2 & ~s3.
REQ-016 On a detected edge, the block SHALL sample rx_data in the same cycle and push it.
REQ-017 Masking: bits at index >= char_size SHALL be stored as 0; char_size < 5 or > 8 SHALL be treated as 8, with no masking.
REQ-018 Latency: after a rx_rdy rise, the push SHALL occur on the 3rd rising clk edge (empty falls and count increments there).
REQ-019 Pop: rd_en & ~empty SHALL load rd_data from the head entry on the next edge, advance the read pointer, and decrement count.
REQ-020 rd_en while empty SHALL be ignored; rd_data, the pointers and count SHALL be unchanged.
REQ-021 rd_data SHALL hold its value between accepted pops.
REQ-022 Push while full, without a simultaneous pop: the byte SHALL be dropped, the write pointer and count SHALL be unchanged, and overrun SHALL be set.
REQ-023 Push and pop in the same cycle while full: both SHALL be accepted, count SHALL be unchanged, and overrun SHALL not be set.
REQ-024 Push and pop in the same cycle while empty: the push SHALL be accepted and the pop ignored; count SHALL become 1.
REQ-025 Push and pop in the same cycle otherwise: both SHALL be accepted and count SHALL be unchanged.
REQ-026 Read and write pointers SHALL be ADDR_W bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-027 full and empty SHALL be derived from count and SHALL be registered-consistent: never both high.
REQ-028 overrun SHALL stay set until ovr_clr is high; if set and clear occur in the same cycle, set SHALL win.
REQ-029 A held-high rx_rdy SHALL produce exactly one push; a new push requires rx_rdy to go low and then high again.

Reset
REQ-030 On rst high at a clk edge, the block SHALL set: pointers = 0, count = 0, empty = 1, full = 0, overrun = 0, rd_data = 8'h00, and s1/s2/s3 = 1 (receiver idles ready; no false edge leaving reset).
REQ-031 Reset mid-operation SHALL discard all stored bytes.
REQ-032 A rx_rdy rise whose detected edge coincides with rst high SHALL not be pushed.
REQ-033 rst SHALL take priority over push, pop and ovr_clr.

Verification
REQ-034 Single byte: char_size=8; rx_data=8'hA5; pulse rx_rdy low then high -> 3 clk later empty=0, count=1; rd_en for 1 cycle -> next cycle rd_data=8'hA5, empty=1.
REQ-035 Masking: char_size=5; rx_data=8'hFF; rx_rdy rise -> pop returns 8'h1F. char_size=3 -> pop returns 8'hFF.
REQ-036 Fill and overrun: push 9 bytes 8'h01..8'h09 with DEPTH=8 -> full=1 after the 8th, overrun=1 after the 9th; 8 pops return 01..08; ovr_clr -> overrun=0.
REQ-037 Full boundary: full FIFO; rd_en coincident with a push of 8'h55 -> count stays 8, overrun=0, and 8'h55 is the last byte popped.
REQ-038 Wrap: 20 push/pop pairs of incrementing bytes, interleaved -> all popped in order, pointers wrap, empty=1 at end.
REQ-039 Reset: 3 bytes stored; assert rst for 1 cycle -> count=0, empty=1, rd_data=8'h00; rx_rdy held high through reset -> no push afterwards.
